// File: rtl/fp_add_issue_collect.sv
// Operand issuer and in-order result collector for an external pipelined FP adder.
// Credit-based flow control ensures every issued pair has a FIFO slot when its sum emerges.
module fp_add_issue_collect #(
    parameter int LATENCY    = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] Number1,
    output logic [31:0] Number2,
    input  logic [31:0] Result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic [4:0]  inflight,
    output logic [15:0] done_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

    logic [LATENCY-1:0] vpipe_r;
    logic [31:0]        mem_r [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      fifo_count_r;
    logic [CW-1:0]      inflight_r;
    logic [31:0]        number1_r;
    logic [31:0]        number2_r;
    logic               out_valid_r;
    logic [31:0]        out_sum_r;
    logic [15:0]        done_count_r;

    logic               in_fire_s;
    logic               out_fire_s;
    logic               capture_s;
    logic [CW:0]        credits_s;
    logic [CW-1:0]      fifo_count_next_s;
    logic [CW-1:0]      count_after_pop_s;
    logic [PW-1:0]      rd_ptr_next_s;
    logic [31:0]        head_next_s;

    function automatic logic [4:0] sat_inflight(input logic [CW-1:0] v);
        if (32'(v) > 32'd31) begin
            return 5'd31;
        end else begin
            return 5'(v);
        end
    endfunction

    // Handshake qualifiers and credit check
    always_comb begin
        credits_s  = {1'b0, inflight_r} + {1'b0, fifo_count_r};
        in_ready   = (credits_s < DEPTH_C);
        in_fire_s  = in_valid & in_ready;
        out_fire_s = out_valid_r & out_ready;
        capture_s  = vpipe_r[LATENCY-1];
    end

    // Next FIFO head; a capture into a FIFO that empties this edge becomes the new head directly
    always_comb begin
        rd_ptr_next_s     = rd_ptr_r + PW'(out_fire_s);
        count_after_pop_s = fifo_count_r - CW'(out_fire_s);
        fifo_count_next_s = count_after_pop_s + CW'(capture_s);
        if (fifo_count_next_s == {CW{1'b0}}) begin
            head_next_s = 32'h0000_0000;
        end else if (count_after_pop_s == {CW{1'b0}}) begin
            head_next_s = Result;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Operand registers, valid pipe, pointers, counters and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vpipe_r      <= '0;
            number1_r    <= 32'h0000_0000;
            number2_r    <= 32'h0000_0000;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
            inflight_r   <= '0;
            out_valid_r  <= 1'b0;
            out_sum_r    <= 32'h0000_0000;
            done_count_r <= 16'h0000;
        end else begin
            number1_r  <= in_fire_s ? in_a : 32'h0000_0000;
            number2_r  <= in_fire_s ? in_b : 32'h0000_0000;
            vpipe_r[0] <= in_fire_s;
            for (int i = 1; i < LATENCY; i++) begin
                vpipe_r[i] <= vpipe_r[i-1];
            end
            case ({in_fire_s, capture_s})
                2'b10:   inflight_r <= inflight_r + CW'(1);
                2'b01:   inflight_r <= inflight_r - CW'(1);
                default: inflight_r <= inflight_r;
            endcase
            fifo_count_r <= fifo_count_next_s;
            if (capture_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            rd_ptr_r    <= rd_ptr_next_s;
            out_valid_r <= (fifo_count_next_s != {CW{1'b0}});
            out_sum_r   <= head_next_s;
            if (out_fire_s) begin
                done_count_r <= done_count_r + 16'd1;
            end
        end
    end

    // Result storage; contents are qualified by the pointers and count, so no reset needed
    always_ff @(posedge clk) begin
        if (capture_s) begin
            mem_r[wr_ptr_r] <= Result;
        end
    end

    assign Number1    = number1_r;
    assign Number2    = number2_r;
    assign out_valid  = out_valid_r;
    assign out_sum    = out_sum_r;
    assign inflight   = sat_inflight(inflight_r);
    assign done_count = done_count_r;

endmodule

// File: tb/tb_fp_add_issue_collect.sv
// Directed bench: behavioural 5-stage adder stand-in plus an in-order result scoreboard.
module tb_fp_add_issue_collect;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] Number1;
    logic [31:0] Number2;
    logic [31:0] Result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [4:0]  inflight;
    logic [15:0] done_count;

    int passed = 0;
    int checks = 0;
    int acc    = 0;
    int dlv    = 0;
    logic [31:0] exp_q [$];
    logic [31:0] stage [4];
    logic [9:0]  vec;

    fp_add_issue_collect #(.LATENCY(5), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .Number1(Number1), .Number2(Number2), .Result(Result),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .inflight(inflight), .done_count(done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed sums for the operand pairs used here
    function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h0000_0000) return b;
        if (a == 32'h42C6_0000 && b == 32'h4332_0000) return 32'h438A_8000;
        if (a == 32'h42C2_0000 && b == 32'hC29E_0000) return 32'h4190_0000;
        if (a == 32'hC25C_0000 && b == 32'h4296_0000) return 32'h41A0_0000;
        if (a == 32'hC38C_0000 && b == 32'hC28A_0000) return 32'hC3AE_8000;
        return 32'hDEAD_BEEF;
    endfunction

    // Adder stand-in: Number1/Number2 registered at edge t give Result valid before edge t+5
    always @(posedge clk) begin
        stage[0] <= add_model(Number1, Number2);
        for (int i = 1; i < 4; i++) stage[i] <= stage[i-1];
    end
    assign Result = stage[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        if (in_valid && in_ready) begin
            exp_q.push_back(add_model(in_a, in_b));
            acc++;
        end
        if (out_valid && out_ready) begin
            dlv++;
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) passed++;
                else $error("FAIL unexpected_out: observed sum %h expected no output", out_sum);
            end else begin
                chk("out_sum", out_sum, exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = 32'h0; in_b = 32'h0;
        for (int i = 0; i < 4; i++) stage[i] = 32'h0;
        #1;
        tick(); tick(); tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_number1", Number1, 32'h0);
        chk("rst_out_sum", out_sum, 32'h0);
        chk("rst_done", {16'b0, done_count}, 32'd0);
        chk("rst_inflight", {27'b0, inflight}, 32'd0);
        reset = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // single pair: 99 + 178
        out_ready = 1'b1;
        in_a = 32'h42C6_0000; in_b = 32'h4332_0000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("issue_n1", Number1, 32'h42C6_0000);
        chk("issue_n2", Number2, 32'h4332_0000);
        chk("issue_inflight", {27'b0, inflight}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("early_valid", {31'b0, out_valid}, 32'd0);
        end
        chk("idle_n1", Number1, 32'h0);
        tick();
        chk("lat_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_sum", out_sum, 32'h438A_8000);
        chk("lat_inflight", {27'b0, inflight}, 32'd0);
        tick();
        chk("pulse_end", {31'b0, out_valid}, 32'd0);
        chk("done_1", {16'b0, done_count}, 32'd1);

        // back-to-back pairs
        in_a = 32'h42C2_0000; in_b = 32'hC29E_0000; in_valid = 1'b1; tick();
        in_a = 32'hC25C_0000; in_b = 32'h4296_0000; tick();
        in_a = 32'hC38C_0000; in_b = 32'hC28A_0000; tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            vec[k] = out_valid;
        end
        chk("b2b_pattern", {22'b0, vec}, 32'h0000_001C);
        chk("b2b_empty", exp_q.size(), 32'd0);
        chk("done_4", {16'b0, done_count}, 32'd4);

        // credit limit with consumer stalled
        out_ready = 1'b0; in_a = 32'h0; in_b = 32'hC2E2_0000; acc = 0;
        for (int k = 0; k < 14; k++) begin
            in_valid = (acc < 10);
            tick();
        end
        chk("credit_accepts", acc, 32'd8);
        chk("credit_ready", {31'b0, in_ready}, 32'd0);
        chk("credit_inflight", {27'b0, inflight}, 32'd0);
        chk("credit_head", out_sum, 32'hC2E2_0000);
        out_ready = 1'b1; dlv = 0;
        for (int k = 0; k < 30; k++) begin
            in_valid = (acc < 10);
            tick();
        end
        in_valid = 1'b0;
        chk("credit_total", acc, 32'd10);
        chk("credit_delivered", dlv, 32'd10);
        chk("credit_empty", exp_q.size(), 32'd0);
        chk("done_14", {16'b0, done_count}, 32'd14);

        // toggling consumer with continuous input, distinct data to expose wrap errors
        acc = 0; in_a = 32'h0;
        for (int k = 0; k < 40; k++) begin
            in_valid = 1'b1;
            in_b = 32'h4000_0000 | 32'(k);
            out_ready = k[0];
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        chk("tog_done", {16'b0, done_count}, 32'(14 + acc));
        chk("tog_empty", exp_q.size(), 32'd0);
        chk("tog_valid", {31'b0, out_valid}, 32'd0);
        chk("tog_inflight", {27'b0, inflight}, 32'd0);

        // reset with 3 in flight and 2 in the FIFO
        out_ready = 1'b0; in_a = 32'h42C6_0000; in_b = 32'h4332_0000;
        in_valid = 1'b1; tick(); tick();
        in_valid = 1'b0; tick(); tick();
        in_valid = 1'b1; tick(); tick(); tick();
        in_valid = 1'b0;
        chk("pre_rst_inflight", {27'b0, inflight}, 32'd3);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_sum", out_sum, 32'h0);
        chk("mid_rst_n1", Number1, 32'h0);
        chk("mid_rst_n2", Number2, 32'h0);
        chk("mid_rst_inflight", {27'b0, inflight}, 32'd0);
        chk("mid_rst_done", {16'b0, done_count}, 32'd0);
        exp_q.delete();
        tick(); tick();
        reset = 1'b0;
        chk("post_rst_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("post_rst_quiet", {31'b0, out_valid}, 32'd0);
        end

        // idle
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_valid", {31'b0, out_valid}, 32'd0);
        end
        chk("idle_n1_end", Number1, 32'h0);
        chk("idle_n2_end", Number2, 32'h0);
        chk("idle_done", {16'b0, done_count}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
